jtpopeye_txt: RTL and testbench

- Text (character) layer generator for the Popeye video path.
- Holds tile-code and tile-colour RAM written by the main CPU, and the 1bpp character ROM loaded through the PROM programming bus.
- Fetches tiles one column ahead of the beam and serialises 8-pixel rows.
- Drives txtc/txtv straight into the colour mixer: txtv low means an opaque text pixel, which wins priority.

---
 rtl/jtpopeye_pkg.sv | 19 +
 rtl/jtpopeye_txt_if.sv | 11 +
 rtl/jtgng_prom.sv | 24 ++
 rtl/jtpopeye_txt_dpram.sv | 41 ++++
 rtl/jtpopeye_txt.sv | 152 +++++++++++++++
 tb/tb_jtpopeye_txt.sv | 253 +++++++++++++++++++++++++
 6 files changed

// File: rtl/jtpopeye_pkg.sv
// Shared constants and helpers for the Popeye text layer.
package jtpopeye_pkg;

    localparam int TXT_COLS = 32;
    localparam int TXT_ROWS = 32;

    // Fetch phases, keyed by H[2:0] on pixel-enable edges
    localparam logic [2:0] PH_CODE  = 3'd0;
    localparam logic [2:0] PH_COL   = 3'd1;
    localparam logic [2:0] PH_ROM   = 3'd2;
    localparam logic [2:0] PH_LATCH = 3'd4;
    localparam logic [2:0] PH_LOAD  = 3'd7;

    // Tile RAM address: row-major, one byte per tile, 32 tiles per row
    function automatic logic [9:0] tile_addr(input logic [4:0] row, input logic [4:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/jtpopeye_txt_if.sv
// CPU access bus to the text code/colour RAMs.
interface jtpopeye_txt_if;
    logic [10:0] cpu_AB;
    logic        cpu_cs;
    logic        cpu_wrn;
    logic [7:0]  cpu_dout;
    logic [7:0]  txt_dout;

    modport master (output cpu_AB, cpu_cs, cpu_wrn, cpu_dout, input txt_dout);
    modport slave  (input cpu_AB, cpu_cs, cpu_wrn, cpu_dout, output txt_dout);
endinterface

// File: rtl/jtgng_prom.sv
// Programmable ROM: written through the PROM bus, read with a registered port.
module jtgng_prom #(
    parameter int dw      = 8,
    parameter int aw      = 11,
    parameter     simfile = ""
)(
    input  logic          clk,
    input  logic          cen,
    input  logic [dw-1:0] data,
    input  logic [aw-1:0] rd_addr,
    input  logic [aw-1:0] wr_addr,
    input  logic          we,
    output logic [dw-1:0] q
);

    logic [dw-1:0] mem [0:(1<<aw)-1];

    // Independent programming write and video read
    always_ff @(posedge clk) begin
        if (we)  mem[wr_addr] <= data;
        if (cen) q <= mem[rd_addr];
    end

endmodule

// File: rtl/jtpopeye_txt_dpram.sv
// True dual-port, read-first RAM with registered reads on both ports.
module jtpopeye_txt_dpram #(
    parameter int AW = 10,
    parameter int DW = 8
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    output logic [DW-1:0] q_a,
    input  logic          en_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] din_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Storage writes from either port
    // NOTE: the array itself has no reset; resetting it would turn the RAM into flops.
    always_ff @(posedge clk) begin
        if (en_a && we_a) mem[addr_a] <= din_a;
        if (en_b && we_b) mem[addr_b] <= din_b;
    end

    // Registered reads; they see pre-edge contents, so a same-address write is read-first
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here make every read sample the array before this edge's writes land.
        if (!rst_n) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (en_a) q_a <= mem[addr_a];
            if (en_b) q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/jtpopeye_txt.sv
// Popeye text layer: tile fetch one column ahead of the beam, 1bpp row serialiser.
module jtpopeye_txt
    import jtpopeye_pkg::*;
#(
    parameter logic [7:0] ROW_OFFSET = 8'd16,
    parameter             SIMFILE    = "../../rom/tpp2-v.7j"
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic [8:0]  H,
    input  logic [7:0]  V,
    input  logic        HB_n,
    input  logic        flip,
    jtpopeye_txt_if.slave cpu,
    input  logic [10:0] prog_addr,
    input  logic [7:0]  prog_din,
    input  logic        rom_we,
    output logic [3:0]  txtc,
    output logic        txtv
);

    localparam int RAM_AW = $clog2(TXT_COLS * TXT_ROWS);

    logic [7:0]  vt;
    logic [2:0]  phase;
    logic [4:0]  cn;
    logic [9:0]  code_addr;
    logic [2:0]  line;
    logic [10:0] rom_addr;
    logic        pix;

    logic [7:0]  code_qa, code_qb, col_qa, col_qb, rom_q;
    logic        code_sel, col_sel, col_rd_sel;

    logic [9:0]  tile_f;
    logic        flip_f, flip_act;
    logic [7:0]  code_r, pend_row, shift;
    logic [3:0]  pend_col, col_act;
    logic        unused_col_hi;

    // Beam-position decode for the tile being fetched and the pixel being shown
    always_comb begin
        // NOTE: every signal is assigned on every pass so no latch can be inferred.
        vt        = V + ROW_OFFSET;
        phase     = H[2:0];
        cn        = H[7:3] + 5'd1;
        code_addr = tile_addr(flip ? ~vt[7:3] : vt[7:3], flip ? ~cn : cn);
        line      = flip_f ? ~vt[2:0] : vt[2:0];
        rom_addr  = {code_r, line};
        pix       = flip_act ? shift[0] : shift[7];
    end

    assign code_sel      = cpu.cpu_cs & ~cpu.cpu_AB[10];
    assign col_sel       = cpu.cpu_cs &  cpu.cpu_AB[10];
    assign cpu.txt_dout  = col_rd_sel ? col_qa : code_qa;
    assign unused_col_hi = ^col_qb[7:4];

    jtpopeye_txt_dpram #(.AW(RAM_AW), .DW(8)) u_code (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_a   (code_sel),
        .we_a   (~cpu.cpu_wrn),
        .addr_a (cpu.cpu_AB[9:0]),
        .din_a  (cpu.cpu_dout),
        .q_a    (code_qa),
        .en_b   (pxl_cen && phase == PH_CODE),
        .we_b   (1'b0),
        .addr_b (code_addr),
        .din_b  (8'd0),
        .q_b    (code_qb)
    );

    jtpopeye_txt_dpram #(.AW(RAM_AW), .DW(8)) u_colour (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_a   (col_sel),
        .we_a   (~cpu.cpu_wrn),
        .addr_a (cpu.cpu_AB[9:0]),
        .din_a  (cpu.cpu_dout),
        .q_a    (col_qa),
        .en_b   (pxl_cen && phase == PH_COL),
        .we_b   (1'b0),
        .addr_b (tile_f),
        .din_b  (8'd0),
        .q_b    (col_qb)
    );

    jtgng_prom #(.dw(8), .aw(11), .simfile(SIMFILE)) u_chrom (
        .clk     (clk),
        .cen     (pxl_cen && phase == PH_ROM),
        .data    (prog_din),
        .rd_addr (rom_addr),
        .wr_addr (prog_addr),
        .we      (rom_we),
        .q       (rom_q)
    );

    // Remember which bank the last CPU access addressed, for the readback mux
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          col_rd_sel <= 1'b0;
        else if (cpu.cpu_cs) col_rd_sel <= cpu.cpu_AB[10];
    end

    // Fetch pipeline: code, colour and character row for the next column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_f   <= '0;
            flip_f   <= 1'b0;
            code_r   <= '0;
            pend_col <= '0;
            pend_row <= '0;
        end else if (pxl_cen) begin
            case (phase)
                PH_CODE:  begin
                    tile_f <= code_addr;
                    flip_f <= flip;
                end
                PH_COL:   code_r   <= code_qb;
                PH_ROM:   pend_col <= col_qb[3:0];
                PH_LATCH: pend_row <= rom_q;
                default:  ;
            endcase
        end
    end

    // Serialise the active row and drive the mixer; blanking forces transparency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '0;
            col_act  <= '0;
            flip_act <= 1'b0;
            txtc     <= '0;
            txtv     <= 1'b1;
        end else if (pxl_cen) begin
            if (phase == PH_LOAD) begin
                shift    <= pend_row;
                col_act  <= pend_col;
                flip_act <= flip_f;
            end else begin
                shift <= flip_act ? {1'b0, shift[7:1]} : {shift[6:0], 1'b0};
            end
            if (HB_n && !H[8]) begin
                txtv <= ~pix;
                txtc <= col_act;
            end else begin
                txtv <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtpopeye_txt.sv
// Directed bench for the Popeye text layer.
`timescale 1ns/1ps
module tb_jtpopeye_txt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pxl_cen = 1'b1;
    logic [8:0]  H = '0;
    logic [7:0]  V = '0;
    logic        HB_n = 1'b0;
    logic        flip = 1'b0;
    logic [10:0] prog_addr = '0;
    logic [7:0]  prog_din = '0;
    logic        rom_we = 1'b0;
    logic [3:0]  txtc;
    logic        txtv;

    jtpopeye_txt_if cpu();

    jtpopeye_txt u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pxl_cen   (pxl_cen),
        .H         (H),
        .V         (V),
        .HB_n      (HB_n),
        .flip      (flip),
        .cpu       (cpu),
        .prog_addr (prog_addr),
        .prog_din  (prog_din),
        .rom_we    (rom_we),
        .txtc      (txtc),
        .txtv      (txtv)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-line capture
    logic       pv [0:255];
    logic [3:0] pc [0:255];
    int         pre_opaque;
    logic [3:0] pre_c_last;
    int         gate_bad;
    logic       rst_v;
    logic [3:0] rst_c;
    logic [7:0] rst_d;
    logic [7:0] coll_rd;
    logic [7:0] rd_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d);
        cpu.cpu_AB = a; cpu.cpu_dout = d; cpu.cpu_cs = 1'b1; cpu.cpu_wrn = 1'b0;
        tick();
        cpu.cpu_cs = 1'b0; cpu.cpu_wrn = 1'b1;
    endtask

    task automatic cpu_rd(input logic [10:0] a, output logic [7:0] d);
        cpu.cpu_AB = a; cpu.cpu_cs = 1'b1; cpu.cpu_wrn = 1'b1;
        tick();
        d = cpu.txt_dout;
        cpu.cpu_cs = 1'b0;
    endtask

    task automatic rom_wr(input logic [10:0] a, input logic [7:0] d);
        prog_addr = a; prog_din = d; rom_we = 1'b1;
        tick();
        rom_we = 1'b0;
    endtask

    function automatic int opaque_cnt(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (pv[i] == 1'b0) n++;
        return n;
    endfunction

    // One line: 8 blank pixels at H=0x1F8..0x1FF (prefetch column 0), then H=0..255 visible.
    // gate_at / rst_at (or -1) insert a pxl_cen freeze or an async reset before that H.
    task automatic scan_line(input logic [7:0] v, input int gate_at, input int rst_at, input bit collide);
        logic       fv;
        logic [3:0] fc;
        V = v;
        HB_n = 1'b0;
        pre_opaque = 0;
        for (int i = 0; i < 8; i++) begin
            H = {6'b111111, i[2:0]};
            tick();
            if (txtv == 1'b0) pre_opaque++;
        end
        pre_c_last = txtc;
        HB_n = 1'b1;
        for (int h = 0; h < 256; h++) begin
            H = h[8:0];
            if (collide && h == 0) begin
                cpu.cpu_AB = 11'h041; cpu.cpu_dout = 8'h77; cpu.cpu_cs = 1'b1; cpu.cpu_wrn = 1'b0;
            end
            if (collide && h == 1) cpu.cpu_wrn = 1'b1;
            if (h == gate_at) begin
                fv = txtv; fc = txtc;
                pxl_cen = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    if (txtv !== fv || txtc !== fc) gate_bad++;
                end
                pxl_cen = 1'b1;
            end
            if (h == rst_at) begin
                rst_n = 1'b0;
                #1;
                rst_v = txtv; rst_c = txtc; rst_d = cpu.txt_dout;
            end
            if (rst_at >= 0 && h == rst_at + 3) rst_n = 1'b1;
            tick();
            if (collide && h == 1) begin
                coll_rd = cpu.txt_dout;
                cpu.cpu_cs = 1'b0;
            end
            pv[h] = txtv;
            pc[h] = txtc;
        end
        HB_n = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        cpu.cpu_AB = '0; cpu.cpu_cs = 1'b0; cpu.cpu_wrn = 1'b1; cpu.cpu_dout = '0;
        gate_bad = 0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_txtv", txtv, 1'b1);
        check("rst_txtc", txtc, 4'h0);
        check("rst_dout", cpu.txt_dout, 8'h00);
        repeat (3) tick();
        rst_n = 1'b1;

        // Blank out every tile and every character row
        for (int a = 0; a < 2048; a++) cpu_wr(a[10:0], 8'h00);
        for (int a = 0; a < 2048; a++) rom_wr(a[10:0], 8'h00);

        // Single character: row 2, column 1, code 0x12, colour 5, line 3 = 0x81
        rom_wr(11'h093, 8'h81);
        cpu_wr(11'h041, 8'h12);
        cpu_wr(11'h441, 8'h05);
        scan_line(8'd3, -1, -1, 1'b0);
        check("single_pre_blank", pre_opaque, 0);
        check("single_h8_v", pv[8], 1'b0);
        check("single_h8_c", pc[8], 4'h5);
        check("single_h9_14", opaque_cnt(9, 14), 0);
        check("single_h15_v", pv[15], 1'b0);
        check("single_h15_c", pc[15], 4'h5);
        check("single_line_cnt", opaque_cnt(0, 255), 2);

        // pxl_cen held low mid-tile
        scan_line(8'd3, 11, -1, 1'b0);
        check("gate_frozen", gate_bad, 0);
        check("gate_h8_v", pv[8], 1'b0);
        check("gate_h9_14", opaque_cnt(9, 14), 0);
        check("gate_h15_v", pv[15], 1'b0);
        check("gate_line_cnt", opaque_cnt(0, 255), 2);

        // Async reset mid-tile at H=0x23
        cpu_wr(11'h044, 8'h12);
        cpu_wr(11'h444, 8'h09);
        cpu_wr(11'h046, 8'h12);
        cpu_wr(11'h446, 8'h03);
        cpu_rd(11'h041, rd_val);
        check("rd_code_041", rd_val, 8'h12);
        scan_line(8'd3, -1, 'h23, 1'b0);
        check("prerst_h20_v", pv['h20], 1'b0);
        check("prerst_h20_c", pc['h20], 4'h9);
        check("rst_mid_txtv", rst_v, 1'b1);
        check("rst_mid_txtc", rst_c, 4'h0);
        check("rst_mid_dout", rst_d, 8'h00);
        check("postrst_col5", opaque_cnt('h28, 'h2F), 0);
        check("postrst_h30_v", pv['h30], 1'b0);
        check("postrst_h30_c", pc['h30], 4'h3);
        check("postrst_h31_36", opaque_cnt('h31, 'h36), 0);
        check("postrst_h37_v", pv['h37], 1'b0);
        cpu_wr(11'h044, 8'h00);
        cpu_wr(11'h046, 8'h00);

        // Flip: V=220 -> Vt=236, row 29 line 4, inverted to row 2 line 3; screen col 30 fetches col 1
        rom_wr(11'h093, 8'h07);
        flip = 1'b1;
        scan_line(8'd220, -1, -1, 1'b0);
        check("flip_h240_v", pv[240], 1'b0);
        check("flip_h240_c", pc[240], 4'h5);
        check("flip_h242_v", pv[242], 1'b0);
        check("flip_h243_v", pv[243], 1'b1);
        check("flip_h247_v", pv[247], 1'b1);
        check("flip_line_cnt", opaque_cnt(0, 255), 3);
        flip = 1'b0;

        // Blanking and column 31 -> column 0 wrap
        rom_wr(11'h093, 8'h81);
        cpu_wr(11'h040, 8'h12);
        cpu_wr(11'h440, 8'h06);
        cpu_wr(11'h05F, 8'h12);
        cpu_wr(11'h45F, 8'h0A);
        scan_line(8'd3, -1, -1, 1'b0);
        check("wrap1_h0_v", pv[0], 1'b0);
        check("wrap1_h248_c", pc[248], 4'hA);
        scan_line(8'd3, -1, -1, 1'b0);
        check("blank_opaque", pre_opaque, 0);
        check("blank_txtc_hold", pre_c_last, 4'hA);
        check("wrap2_h0_v", pv[0], 1'b0);
        check("wrap2_h0_c", pc[0], 4'h6);
        check("wrap2_h7_v", pv[7], 1'b0);
        check("wrap2_h248_v", pv[248], 1'b0);
        check("wrap2_h255_v", pv[255], 1'b0);
        check("wrap2_h255_c", pc[255], 4'hA);
        check("wrap2_line_cnt", opaque_cnt(0, 255), 6);

        // CPU write collides with the video fetch of 0x041 at H=0
        rom_wr(11'h094, 8'hF0);
        rom_wr(11'h3BC, 8'h0F);
        scan_line(8'd3, -1, -1, 1'b1);
        check("coll_old_h8", pv[8], 1'b0);
        check("coll_old_h15", pv[15], 1'b0);
        check("coll_old_h9_14", opaque_cnt(9, 14), 0);
        check("coll_readback", coll_rd, 8'h77);
        scan_line(8'd4, -1, -1, 1'b0);
        check("coll_new_h8", pv[8], 1'b1);
        check("coll_new_h12_v", pv[12], 1'b0);
        check("coll_new_h12_c", pc[12], 4'h5);
        check("coll_new_cnt", opaque_cnt(8, 15), 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
